// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port memory with a registered IDLE/WAIT_ACK/DONE FSM.
// Optional WAIT_ACK timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_di,
    input  logic [DATA_W-1:0] m1_di,
    output logic [DATA_W-1:0] m0_do,
    output logic [DATA_W-1:0] m1_do,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    input  logic              mem_do_ack,
    output logic              busy,
    output logic              grant,
    output logic [1:0]        dbg_state_o
);
    // Handshake: a master holds mN_req until its one-cycle mN_ack; mem_do_ack is a
    // completion strobe from memory and is only honoured while in WAIT_ACK.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                grant_q, busy_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_di_q;
    logic [DATA_W-1:0]   m0_do_q, m1_do_q;
    logic                m0_ack_q, m1_ack_q;
    logic                win_d, tmo_d, done_d, err_d;
    logic [DATA_W-1:0]   rdata_d;

    // On a tie the master that did not own the last transaction wins.
    assign win_d = (m0_req && m1_req) ? ~last_grant_q : m1_req;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       m0_err_q, m1_err_q;
    assign tmo_d  = (cnt_q == 8'(TIMEOUT - 1));
    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign tmo_d  = 1'b0;
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    // A real memory ack beats a simultaneous timeout.
    assign done_d  = mem_do_ack || tmo_d;
    assign err_d   = !mem_do_ack && tmo_d;
    assign rdata_d = mem_do_ack ? mem_do : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_di_q     <= '0;
            m0_do_q      <= '0;
            m1_do_q      <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_q    <= win_d;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= win_d ? m1_we : m0_we;
                        mem_addr_q <= win_d ? m1_addr : m0_addr;
                        mem_di_q   <= win_d ? m1_di : m0_di;
                        busy_q     <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_d) begin
                        if (grant_q) begin
                            m1_do_q  <= rdata_d;
                            m1_ack_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                            m1_err_q <= err_d;
`endif
                        end else begin
                            m0_do_q  <= rdata_d;
                            m0_ack_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                            m0_err_q <= err_d;
`endif
                        end
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        busy_q       <= 1'b0;
                        last_grant_q <= grant_q;
                        state_q      <= S_DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifndef MEM_ARB_TIMEOUT_EN
    logic unused_err;
    assign unused_err = err_d;
`endif

    assign m0_do       = m0_do_q;
    assign m1_do       = m1_do_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_di      = mem_di_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign dbg_state_o = state_q;
endmodule
